// File: rtl/hdu_pkg.sv
// Shared types and encodings for the hazard detection unit.
// Optional perf counters in the top are enabled with HDU_PERF_CNT_EN.
package hdu_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [OP_W-1:0] {
    NONE  = 2'b00,
    ALU   = 2'b01,
    LOAD  = 2'b10,
    STORE = 2'b11
  } optype_e;

  localparam logic [FWD_W-1:0] FWD_RF   = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEML = 2'b11;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    optype_e          optype;
  } hdu_rec_t;

  localparam hdu_rec_t REC_EMPTY = '{rd: '0, optype: NONE};

endpackage

// File: rtl/hdu_stage_tracker.sv
// EX/MEM/WB destination record shift chain; a bubble loads an empty EX record.
module hdu_stage_tracker
  import hdu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  hdu_rec_t id_rec,
  input  logic     bubble,
  output hdu_rec_t ex_rec,
  output hdu_rec_t mem_rec,
  output hdu_rec_t wb_rec
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rec  <= REC_EMPTY;
      mem_rec <= REC_EMPTY;
      wb_rec  <= REC_EMPTY;
    end else begin
      ex_rec  <= bubble ? REC_EMPTY : id_rec;
      mem_rec <= ex_rec;
      wb_rec  <= mem_rec;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Forwarding select, load-use stall and branch flush control for a 5-stage pipe.
// Define HDU_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module hazard_detection_unit
  import hdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic [REG_W-1:0] rd_ID,
  input  logic             rs1use,
  input  logic             rs2use,
  input  logic [OP_W-1:0]  hazard_optype,
  input  logic             Branch_ID,
  output logic [FWD_W-1:0] forward_ctrl_A,
  output logic [FWD_W-1:0] forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  hdu_rec_t id_rec, ex_rec, mem_rec, wb_rec;
  optype_e  id_op;
  logic     load_hit_rs1, load_hit_rs2, store_bypass, stall, ls_q;
  logic     unused_wb;

  assign id_op  = optype_e'(hazard_optype);
  assign id_rec = '{rd: rd_ID, optype: id_op};

  hdu_stage_tracker u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .id_rec  (id_rec),
    .bubble  (reg_DE_flush),
    .ex_rec  (ex_rec),
    .mem_rec (mem_rec),
    .wb_rec  (wb_rec)
  );

  // WB record completes the history but no decision depends on it.
  assign unused_wb = ^wb_rec;

  function automatic logic hit(input hdu_rec_t rec, input logic [REG_W-1:0] src,
                               input logic used);
    return used && (rec.rd != '0) && (rec.rd == src);
  endfunction

  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src, input logic used,
                                               input hdu_rec_t ex, input hdu_rec_t mem);
    fwd_sel = FWD_RF;
    if (hit(ex, src, used) && ex.optype == ALU)         fwd_sel = FWD_EX;
    else if (hit(mem, src, used) && mem.optype == ALU)  fwd_sel = FWD_MEM;
    else if (hit(mem, src, used) && mem.optype == LOAD) fwd_sel = FWD_MEML;
  endfunction

  assign load_hit_rs1 = hit(ex_rec, rs1_ID, rs1use) && (ex_rec.optype == LOAD);
  assign load_hit_rs2 = hit(ex_rec, rs2_ID, rs2use) && (ex_rec.optype == LOAD);

  // A store needing the load only as its data operand can take it from WB later.
  assign store_bypass = load_hit_rs2 && !load_hit_rs1 && (id_op == STORE);
  assign stall        = rst_n && (load_hit_rs1 || (load_hit_rs2 && (id_op != STORE)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ls_q <= 1'b0;
    else        ls_q <= store_bypass;
  end

  // Output decode; reset forces the no-hazard values.
  always_comb begin
    forward_ctrl_A  = FWD_RF;
    forward_ctrl_B  = FWD_RF;
    forward_ctrl_ls = 1'b0;
    PC_EN_IF        = 1'b1;
    reg_FD_EN       = 1'b1;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    if (rst_n) begin
      forward_ctrl_A  = fwd_sel(rs1_ID, rs1use, ex_rec, mem_rec);
      forward_ctrl_B  = fwd_sel(rs2_ID, rs2use, ex_rec, mem_rec);
      forward_ctrl_ls = ls_q;
      if (stall) begin
        PC_EN_IF     = 1'b0;
        reg_FD_EN    = 1'b0;
        reg_DE_flush = 1'b1;
      end else if (Branch_ID) begin
        reg_FD_flush = 1'b1;
      end
    end
  end

`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)        stall_cnt <= stall_cnt + CNT_W'(1);
      if (reg_FD_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized bench for hazard_detection_unit with an in-bench pipeline history model.
// Counter checks are included when HDU_PERF_CNT_EN is defined.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_ID = '0;
  logic       rs1use = 1'b0, rs2use = 1'b0, Branch_ID = 1'b0;
  logic [1:0] hazard_optype = '0;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
`ifdef HDU_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] stall_m = '0, flush_m = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  hazard_detection_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use(rs1use), .rs2use(rs2use),
    .hazard_optype(hazard_optype), .Branch_ID(Branch_ID),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .PC_EN_IF(PC_EN_IF),
    .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush)
`ifdef HDU_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Producer history: index 0 is the instruction now in EX, 1 in MEM, 2 in WB.
  int pr_rd[3] = '{0, 0, 0};
  int pr_op[3] = '{0, 0, 0};
  bit ls_m = 1'b0;

  function automatic bit load_in_ex_reads(input int rs, input bit u);
    return u && rs != 0 && pr_op[0] == 2 && pr_rd[0] == rs;
  endfunction

  function automatic bit m_stall();
    bit h1, h2;
    h1 = load_in_ex_reads(int'(rs1_ID), rs1use);
    h2 = load_in_ex_reads(int'(rs2_ID), rs2use);
    return rst_n && (h1 || (h2 && hazard_optype != 2'd3));
  endfunction

  function automatic bit m_ls_next();
    return load_in_ex_reads(int'(rs2_ID), rs2use) && !load_in_ex_reads(int'(rs1_ID), rs1use)
           && hazard_optype == 2'd3;
  endfunction

  function automatic int m_fwd(input int rs, input bit u);
    if (!rst_n || !u || rs == 0) return 0;
    if (pr_rd[0] == rs && pr_op[0] == 1) return 1;
    if (pr_rd[1] == rs && pr_op[1] == 1) return 2;
    if (pr_rd[1] == rs && pr_op[1] == 2) return 3;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_rd = '{0, 0, 0};
      pr_op = '{0, 0, 0};
      ls_m  = 1'b0;
`ifdef HDU_PERF_CNT_EN
      stall_m = '0;
      flush_m = '0;
`endif
    end else begin
      bit st, nls;
      st  = m_stall();
      nls = m_ls_next();
`ifdef HDU_PERF_CNT_EN
      if (st) stall_m = stall_m + 32'd1;
      if (!st && Branch_ID) flush_m = flush_m + 32'd1;
`endif
      pr_rd[2] = pr_rd[1]; pr_op[2] = pr_op[1];
      pr_rd[1] = pr_rd[0]; pr_op[1] = pr_op[0];
      pr_rd[0] = st ? 0 : int'(rd_ID);
      pr_op[0] = st ? 0 : int'(hazard_optype);
      ls_m = nls;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    bit st;
    st = m_stall();
    chk("fwdA", int'(forward_ctrl_A), m_fwd(int'(rs1_ID), rs1use));
    chk("fwdB", int'(forward_ctrl_B), m_fwd(int'(rs2_ID), rs2use));
    chk("fwd_ls", int'(forward_ctrl_ls), int'(rst_n && ls_m));
    chk("pc_en", int'(PC_EN_IF), int'(!st));
    chk("fd_en", int'(reg_FD_EN), int'(!st));
    chk("de_flush", int'(reg_DE_flush), int'(st));
    chk("fd_flush", int'(reg_FD_flush), int'(rst_n && !st && Branch_ID));
`ifdef HDU_PERF_CNT_EN
    chk("stall_cnt", int'(stall_cnt), int'(stall_m));
    chk("flush_cnt", int'(flush_cnt), int'(flush_m));
`endif
  end

  task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic [1:0] op,
                        input logic br);
    rs1_ID = r1; rs1use = u1; rs2_ID = r2; rs2use = u2;
    rd_ID = rd; hazard_optype = op; Branch_ID = br;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic nops();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0);
    repeat (3) adv();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    settle();
    chk("rst_pc_en", int'(PC_EN_IF), 1);
    chk("rst_de_flush", int'(reg_DE_flush), 0);
    adv(); rst_n = 1'b1;
    nops();

    // addi x5 ; add x6,x5,x5
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 2'd1, 1'b0); adv();
    set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 2'd1, 1'b0); settle();
    chk("s1_fwdA", int'(forward_ctrl_A), 1);
    chk("s1_fwdB", int'(forward_ctrl_B), 1);
    chk("s1_pc_en", int'(PC_EN_IF), 1);
    adv(); nops();

    // addi x5 ; nop ; sub x7,x5,x1
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 2'd1, 1'b0); adv();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); adv();
    set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 2'd1, 1'b0); settle();
    chk("s2_fwdA", int'(forward_ctrl_A), 2);
    chk("s2_fwdB", int'(forward_ctrl_B), 0);
    adv(); nops();

    // lw x5 ; add x6,x5,x2
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0); adv();
    set_id(5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 2'd1, 1'b0); settle();
    chk("s3_pc_en", int'(PC_EN_IF), 0);
    chk("s3_de_flush", int'(reg_DE_flush), 1);
    adv(); settle();
    chk("s3_fwdA", int'(forward_ctrl_A), 3);
    chk("s3_pc_en2", int'(PC_EN_IF), 1);
    adv(); nops();

    // lw x5 ; sw x5,0(x3)
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0); adv();
    set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 2'd3, 1'b0); settle();
    chk("s4_pc_en", int'(PC_EN_IF), 1);
    chk("s4_ls0", int'(forward_ctrl_ls), 0);
    adv(); set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); settle();
    chk("s4_ls1", int'(forward_ctrl_ls), 1);
    adv(); nops();

    // lw x5 ; beq x5,x0 taken
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0); adv();
    set_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 2'd0, 1'b1); settle();
    chk("s5_pc_en", int'(PC_EN_IF), 0);
    chk("s5_fd_flush0", int'(reg_FD_flush), 0);
    adv(); settle();
    chk("s5_fd_flush1", int'(reg_FD_flush), 1);
    adv(); nops();

    // addi x0 ; add x6,x0,x0
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 2'd1, 1'b0); adv();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 2'd1, 1'b0); settle();
    chk("s6_fwdA", int'(forward_ctrl_A), 0);
    chk("s6_fwdB", int'(forward_ctrl_B), 0);
    adv(); nops();

    // reset pulse in the middle of a load-use stall
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 2'd2, 1'b0); adv();
    set_id(5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 2'd1, 1'b0); settle();
    chk("s7_stall", int'(PC_EN_IF), 0);
    rst_n = 1'b0; #1;
    chk("s7_rst_pc_en", int'(PC_EN_IF), 1);
    chk("s7_rst_fd_en", int'(reg_FD_EN), 1);
    chk("s7_rst_de_flush", int'(reg_DE_flush), 0);
    adv(); rst_n = 1'b1; settle();
    chk("s7_post_pc_en", int'(PC_EN_IF), 1);
    chk("s7_post_fwdA", int'(forward_ctrl_A), 0);
    adv(); nops();

    // Randomized traffic over a small register set to provoke many matches
    for (int i = 0; i < 3000; i++) begin
      set_id(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 2'($urandom), 1'($urandom_range(0, 7) == 0));
      rst_n = ($urandom_range(0, 63) != 0);
      adv();
    end
    rst_n = 1'b1;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
